// File: rtl/sync_debounce.sv
// sync_debounce: multi-channel conditioner for asynchronous 1-bit pad inputs.
// Each channel has a SYNC_STAGES-flop synchronizer, then a debounce filter that
// accepts a new level only after it has held for DEBOUNCE_CYCLES ticks, then
// registered one-cycle rise/fall strobes. One prescaler sets the tick rate for
// all channels.
//
// Ports:
//   clk    in   1     system clock
//   rst_n  in   1     synchronous active-low reset
//   d_a    in   N_CH  asynchronous raw inputs
//   q      out  N_CH  debounced, synchronized level
//   rise   out  N_CH  one-cycle strobe on q 0->1
//   fall   out  N_CH  one-cycle strobe on q 1->0

// One channel: synchronizer, debounce counter, edge strobes.
module sync_debounce_lane #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic d_a,
  output logic q,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   s;

  assign s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync <= '0;
      cnt  <= '0;
      q    <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], d_a};
      rise <= 1'b0;
      fall <= 1'b0;
      if (s == q) begin
        // Any return to the accepted level restarts the count, tick or not.
        cnt <= '0;
      end else if (tick) begin
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          q    <= s;
          cnt  <= '0;
          rise <= s;
          fall <= ~s;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
endmodule

module sync_debounce #(
  parameter int N_CH            = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PRESCALE        = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] d_a,
  output logic [N_CH-1:0] q,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall
);
  // Keep the prescaler at least one bit wide so PRESCALE==1 still elaborates;
  // it then sits at 0 and tick is constantly high.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  generate
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("sync_debounce: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
      $error("sync_debounce: DEBOUNCE_CYCLES must be >= 1");
    end
    if (PRESCALE < 1) begin : g_bad_pre
      $error("sync_debounce: PRESCALE must be >= 1");
    end
    if (N_CH < 1) begin : g_bad_nch
      $error("sync_debounce: N_CH must be >= 1");
    end
  endgenerate

  logic [PW-1:0] pcnt;
  logic          tick;

  assign tick = (pcnt == PW'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (!rst_n)    pcnt <= '0;
    else if (tick) pcnt <= '0;
    else           pcnt <= pcnt + 1'b1;
  end

  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_lane
      sync_debounce_lane #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_lane (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick),
        .d_a  (d_a[i]),
        .q    (q[i]),
        .rise (rise[i]),
        .fall (fall[i])
      );
    end
  endgenerate
endmodule

// File: tb/tb_sync_debounce.sv
// Directed bench for sync_debounce: a per-edge vector table for reset, latency
// and both edge directions, then hand-written sequences for glitch rejection,
// chatter, simultaneous falls, mid-count reset and a prescaled instance.
module tb_sync_debounce;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] d_a = '0, q, rise, fall;
  logic [N-1:0] d6 = '0, q6, rise6, fall6;

  always #5 clk = ~clk;

  sync_debounce dut (
    .clk  (clk),
    .rst_n(rst_n),
    .d_a  (d_a),
    .q    (q),
    .rise (rise),
    .fall (fall)
  );

  sync_debounce #(.PRESCALE(4), .DEBOUNCE_CYCLES(2)) dut6 (
    .clk  (clk),
    .rst_n(rst_n),
    .d_a  (d6),
    .q    (q6),
    .rise (rise6),
    .fall (fall6)
  );

  // Row i: inputs present at edge i, outputs expected just after edge i.
  typedef struct {
    logic         rs;
    logic [N-1:0] d;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic [N-1:0] f;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input logic rs, input logic [N-1:0] d, input logic [N-1:0] eq,
                     input logic [N-1:0] er, input logic [N-1:0] ef, input int n = 1);
    vec_t v;
    v.rs = rs; v.d = d; v.q = eq; v.r = er; v.f = ef;
    repeat (n) tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic rs, input logic [N-1:0] d);
    @(negedge clk);
    rst_n = rs;
    d_a   = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    int n_q, n_r, n_f, r_at, f_at, found, n_r6, n_f6, n_fe, f5;

    // Reset with inputs high, release, rise after 6 edges.
    add(0, 4'hF, 4'h0, 4'h0, 4'h0, 3);
    add(1, 4'hF, 4'h0, 4'h0, 4'h0, 5);
    add(1, 4'hF, 4'hF, 4'hF, 4'h0);
    add(1, 4'hF, 4'hF, 4'h0, 4'h0, 2);
    // All drop together.
    add(1, 4'h0, 4'hF, 4'h0, 4'h0, 5);
    add(1, 4'h0, 4'h0, 4'h0, 4'hF);
    add(1, 4'h0, 4'h0, 4'h0, 4'h0, 2);
    // Channel 0 alone: up then down, others untouched.
    add(1, 4'h1, 4'h0, 4'h0, 4'h0, 5);
    add(1, 4'h1, 4'h1, 4'h1, 4'h0);
    add(1, 4'h1, 4'h1, 4'h0, 4'h0, 2);
    add(1, 4'h0, 4'h1, 4'h0, 4'h0, 5);
    add(1, 4'h0, 4'h0, 4'h0, 4'h1);
    add(1, 4'h0, 4'h0, 4'h0, 4'h0, 2);

    foreach (tbl[i]) begin
      step(tbl[i].rs, tbl[i].d);
      check($sformatf("vec%0d q/rise/fall", i), {q, rise, fall}, {tbl[i].q, tbl[i].r, tbl[i].f});
    end

    // Channel 1: 3-cycle pulse rejected.
    n_q = 0;
    for (int i = 0; i < 13; i++) begin
      step(1, (i < 3) ? 4'h2 : 4'h0);
      if (q[1] || rise[1] || fall[1]) n_q++;
    end
    check("t3 short glitch reaches q", n_q, 0);

    // Channel 1: 4-cycle pulse passes as a 4-cycle q pulse.
    n_q = 0; n_r = 0; n_f = 0; r_at = -1; f_at = -1;
    for (int i = 0; i < 16; i++) begin
      step(1, (i < 4) ? 4'h2 : 4'h0);
      if (q[1]) n_q++;
      if (rise[1]) begin n_r++; r_at = i; end
      if (fall[1]) begin n_f++; f_at = i; end
    end
    check("t3 q[1] high cycles", n_q, 4);
    check("t3 rise[1] count", n_r, 1);
    check("t3 fall[1] count", n_f, 1);
    check("t3 rise[1] edge", r_at, 5);
    check("t3 fall[1] edge", f_at, 9);

    // Channel 2: chatter every 2 cycles, then held high from edge 20.
    n_r = 0; n_f = 0; r_at = -1;
    for (int i = 0; i < 36; i++) begin
      step(1, (i >= 20 || ((i / 2) % 2 == 0)) ? 4'h4 : 4'h0);
      if (rise[2]) begin n_r++; r_at = i; end
      if (fall[2]) n_f++;
    end
    check("t4 rise[2] count", n_r, 1);
    check("t4 rise[2] edge", r_at, 25);
    check("t4 fall[2] count", n_f, 0);
    check("t4 q final", q, 4'h4);

    // All high, then all low together.
    for (int i = 0; i < 8; i++) step(1, 4'hF);
    check("t5 all high", q, 4'hF);
    n_fe = 0; f5 = 0; n_r = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, 4'h0);
      if (fall != 0) n_fe++;
      if (rise != 0) n_r++;
      if (i == 5) f5 = fall;
    end
    check("t5 fall cycles", n_fe, 1);
    check("t5 fall at edge 5", f5, 4'hF);
    check("t5 no rise", n_r, 0);

    // Same, but reset lands mid-count: q cleared, no pulses at all.
    for (int i = 0; i < 8; i++) step(1, 4'hF);
    check("t5b all high", q, 4'hF);
    n_r = 0;
    step(1, 4'h0);
    step(1, 4'h0);
    step(0, 4'h0);
    check("t5b q in reset", {q, rise, fall}, 12'h0);
    step(0, 4'h0);
    for (int i = 0; i < 10; i++) begin
      step(1, 4'h0);
      if (q != 0 || rise != 0 || fall != 0) n_r++;
    end
    check("t5b activity after reset", n_r, 0);

    // Prescaled instance: step on channel 3.
    @(negedge clk);
    d6 = 4'h8;
    found = -1; n_r6 = 0; n_f6 = 0;
    for (int j = 0; j < 20; j++) begin
      @(posedge clk);
      #1;
      if (q6[3] && found < 0) found = j;
      if (rise6[3]) n_r6++;
      if (fall6 != 0 || q6[2:0] != 0) n_f6++;
    end
    n_vec++;
    if (found < 6 || found > 9) begin
      n_err++;
      $display("FAIL t6 latency: got %0d expected 6..9 edges after capture", found);
    end
    check("t6 rise[3] count", n_r6, 1);
    check("t6 other activity", n_f6, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
